l2_private_bank_adapter: RTL
============================

// Module: l2_private_bank_adapter
// PURPOSE
// - TCDM-slave to single-port-RAM adapter sitting directly upstream of one FPGA private L2 bank.
// - Converts PULP TCDM req/gnt/r_valid handshake into csn/wen/be/addr/wdata bank signals.
// - Generates r_valid with the bank's read latency; returns read data.
// - Contains a zero-fill engine that clears the whole bank after reset or on request.
// PARAMETERS
// - ADDR_WIDTH     12  word-address width of the bank (bank holds 2**ADDR_WIDTH 32-bit words)
// - RAM_LATENCY    1   bank read latency in cycles, legal values 1 or 2 (2 = BRAM output reg)
// - INIT_ON_RESET  1   1: zero-fill bank after reset release; 0: go straight to SERVE
// PORTS
// - clk_i        in   1             clock
// - rst_ni       in   1             asynchronous active-low reset
// - req_i        in   1             TCDM request
// - gnt_o        out  1             TCDM grant; request accepted in cycle req_i & gnt_o
// - add_i        in   32            TCDM byte address; bits [ADDR_WIDTH+1:2] used
// - wen_i        in   1             0 = write, 1 = read
// - be_i         in   4             byte enables (writes only)
// - wdata_i      in   32            write data
// - r_valid_o    out  1             response valid (reads and writes)
// - r_rdata_o    out  32            read data, valid with r_valid_o
// - init_req_i   in   1             single-cycle pulse: start bank zero-fill
// - init_busy_o  out  1             high in DRAIN and INIT states
// - ram_csn_o    out  1             bank chip select, active low
// - ram_wen_o    out  1             bank write enable, active low
// - ram_be_o     out  4             bank byte enables
// - ram_addr_o   out  ADDR_WIDTH    bank word address
// - ram_wdata_o  out  32            bank write data
// - ram_rdata_i  in   32            bank read data, RAM_LATENCY cycles after access
// BEHAVIOUR
// - Reset values:
//   - gnt_o=0, r_valid_o=0, r_rdata_o=0, ram_csn_o=1, ram_wen_o=1, ram_be_o=0
//   - ram_addr_o=0, ram_wdata_o=0, init_busy_o=0
//   - Fill counter = 0; response pipe cleared.
// - FSM states: SERVE, DRAIN, INIT.
//   - After reset: INIT if INIT_ON_RESET=1, else SERVE.
// - SERVE:
//   - gnt_o=1 combinationally (no back-pressure).
//   - On req_i: ram_csn_o=0, ram_wen_o=wen_i, ram_be_o=be_i, ram_wdata_o=wdata_i,
//     ram_addr_o=add_i[ADDR_WIDTH+1:2]. All same-cycle combinational pass-through.
//   - No req_i: ram_csn_o=1, ram_wen_o=1, ram_be_o=0.
// - Response pipe: RAM_LATENCY-deep shift register of {valid, is_read}.
//   - Loaded with {1, wen_i} on each grant; otherwise loaded with {0, 0}.
//   - r_valid_o = last valid stage, exactly RAM_LATENCY cycles after the grant cycle.
//   - r_rdata_o = ram_rdata_i when last stage valid & is_read, else 32'h0.
//   - Back-to-back grants give back-to-back responses; order preserved.
// - init_req_i in SERVE:
//   - A req_i in that same cycle is still granted.
//   - Next state DRAIN: gnt_o=0, bank idle, wait until response pipe empty, then INIT.
// - INIT:
//   - gnt_o=0.
//   - One write per cycle: ram_csn_o=0, ram_wen_o=0, ram_be_o=4'hF, ram_wdata_o=0,
//     ram_addr_o=fill counter.
//   - Counter increments from 0; after writing address 2**ADDR_WIDTH-1 it wraps to 0
//     and FSM returns to SERVE next cycle.
// - init_req_i in DRAIN or INIT is ignored (not queued).
// - Async reset mid-INIT or mid-DRAIN:
//   - Outstanding responses dropped; counter cleared.
//   - Fill restarts from 0 only if INIT_ON_RESET=1.
// - req_i while gnt_o=0: no bank access; requester holds req_i (TCDM rule).
// TESTING (ADDR_WIDTH=4, behavioural bank model)
// - Reset, INIT_ON_RESET=1:
//   - 16 consecutive zero writes, addr 0..15, init_busy_o=1 for exactly 16 cycles.
//   - gnt_o first rises in cycle 17; read of any address returns 0.
// - RAM_LATENCY=1:
//   - Write 0xDEADBEEF be=4'hF @0x8, then read @0x8.
//   - r_valid_o one cycle after each grant; read returns 0xDEADBEEF; write response rdata=0.
// - Byte enables: after above, write 0x00000011 be=4'b0001 @0x8 -> read returns 0xDEADBE11.
// - RAM_LATENCY=2:
//   - 4 back-to-back reads @0x0,0x4,0x8,0xC granted in consecutive cycles.
//   - 4 consecutive r_valid_o starting 2 cycles after first grant, data in order.
// - init_req_i with 2 reads outstanding:
//   - Both responses delivered; gnt_o=0 during DRAIN+INIT.
//   - Fill starts only after pipe empty; later reads return 0.
// - Assert rst_ni low at fill address 7, release:
//   - All outputs at reset values while low; fill restarts at address 0.

Source files
------------

// File: rtl/l2_private_bank_adapter.sv
// l2_private_bank_adapter
// Bridges a PULP TCDM slave port (req/gnt/r_valid) onto one single-port
// private L2 bank (csn/wen/be/addr/wdata, active-low strobes). Requests are
// passed to the bank in the grant cycle. Responses come back after the
// bank's fixed read latency. A zero-fill engine clears the whole bank after
// reset, or on request once all outstanding responses have drained.

module l2_private_bank_adapter #(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned RAM_LATENCY   = 1,    // 1, or 2 when the BRAM output register is used
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // TCDM slave side
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           add_i,
  input  logic                  wen_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  r_valid_o,
  output logic [31:0]           r_rdata_o,
  // zero-fill control
  input  logic                  init_req_i,
  output logic                  init_busy_o,
  // bank side
  output logic                  ram_csn_o,
  output logic                  ram_wen_o,
  output logic [3:0]            ram_be_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  // ST_RESET is the state held while rst_ni is low. It keeps every output at
  // its idle value, then hands over to INIT or SERVE on the first clock after
  // release.
  typedef enum logic [1:0] {
    ST_RESET,
    ST_SERVE,
    ST_DRAIN,
    ST_INIT
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] FILL_LAST = '1;

  state_e                  r_state;
  logic [ADDR_WIDTH-1:0]   r_fill_cnt;
  logic [RAM_LATENCY-1:0]  r_pipe_vld;  // one bit per cycle of bank latency
  logic [RAM_LATENCY-1:0]  r_pipe_rd;   // matching "response carries read data" flag

  logic w_grant;
  logic w_pipe_empty;
  logic w_unused_addr_bits;

  // Only the word-address bits inside the bank reach the RAM.
  assign w_unused_addr_bits = ^{add_i[31:ADDR_WIDTH+2], add_i[1:0]};

  // SERVE never back-pressures, so the grant is simply "we are serving".
  assign gnt_o        = (r_state == ST_SERVE);
  assign w_grant      = req_i & gnt_o;
  assign w_pipe_empty = ~(|r_pipe_vld);
  assign init_busy_o  = (r_state == ST_DRAIN) || (r_state == ST_INIT);

  // The response leaves the last pipe stage, which lines up with the bank's data.
  assign r_valid_o = r_pipe_vld[RAM_LATENCY-1];
  assign r_rdata_o = (r_pipe_vld[RAM_LATENCY-1] & r_pipe_rd[RAM_LATENCY-1]) ? ram_rdata_i : 32'h0;

  // Bank strobes: same-cycle pass-through in SERVE, fill writes in INIT, idle otherwise.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latch).
    ram_csn_o   = 1'b1;
    ram_wen_o   = 1'b1;
    ram_be_o    = 4'h0;
    ram_addr_o  = '0;
    ram_wdata_o = 32'h0;
    unique case (r_state)
      ST_SERVE: begin
        if (req_i) begin
          ram_csn_o   = 1'b0;
          ram_wen_o   = wen_i;
          ram_be_o    = be_i;
          ram_addr_o  = add_i[ADDR_WIDTH+1:2];
          ram_wdata_o = wdata_i;
        end
      end
      ST_INIT: begin
        ram_csn_o   = 1'b0;
        ram_wen_o   = 1'b0;
        ram_be_o    = 4'hF;
        ram_addr_o  = r_fill_cnt;
        ram_wdata_o = 32'h0;
      end
      default: begin
      end
    endcase
  end

  // Response pipe: a grant enters stage 0 and surfaces RAM_LATENCY cycles later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pipe_vld <= '0;
      r_pipe_rd  <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage read its neighbour's previous value, giving a true shift.
      r_pipe_vld[0] <= w_grant;
      r_pipe_rd[0]  <= w_grant & wen_i;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_rd[i]  <= r_pipe_rd[i-1];
      end
    end
  end

  // Control FSM and fill counter. An init request that arrives while already
  // draining or filling is dropped, not queued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_RESET;
      r_fill_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_RESET: begin
          r_state <= INIT_ON_RESET ? ST_INIT : ST_SERVE;
        end
        ST_SERVE: begin
          if (init_req_i) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pipe_empty) begin
            r_state <= ST_INIT;
          end
        end
        ST_INIT: begin
          r_fill_cnt <= r_fill_cnt + 1'b1;  // wraps to 0 after the last word
          if (r_fill_cnt == FILL_LAST) begin
            r_state <= ST_SERVE;
          end
        end
        default: begin
          r_state <= ST_RESET;
        end
      endcase
    end
  end

endmodule
